// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: sequential word fetch over req/gnt/rvalid, buffered
// in a small PC-tagged FIFO, delivered over valid/ready, flushed on redirect.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  logic [31:0]       fetch_pc;
  logic [31:0]       resp_pc;
  logic [31:0]       fifo_instr [DEPTH];
  logic [31:0]       fifo_pc    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard;

  logic [CNT_W:0]    in_use;
  logic              grant;
  logic              drop;
  logic              push;
  logic              pop;
  logic [31:0]       target_pc;
  logic              unused_redirect_lsb;

  // Credit scheme: never have more fetches in flight or buffered than FIFO slots.
  assign in_use      = {1'b0, outstanding} + {1'b0, count};
  assign imem_req    = !rst && !redirect && (in_use < DEPTH_L);
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;
  assign drop        = imem_rvalid && (discard != '0);
  assign push        = imem_rvalid && !drop && !redirect;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign target_pc   = {redirect_pc[31:2], 2'b00};

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect) begin
      // Everything still in flight belongs to the old stream, including any
      // response arriving this very cycle.
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CNT_W'(imem_rvalid);
      discard     <= outstanding - CNT_W'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
      if (drop) begin
        discard <= discard - CNT_W'(1'b1);
      end
      if (push) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]    <= resp_pc;
        wr_ptr             <= wr_ptr + PTR_W'(1'b1);
        resp_pc            <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1'b1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
